// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: synchronise, debounce and gate coin-slot switches into single-cycle coin pulses
// Channel index 0 is the 0.5 coin and index 1 is the 1 coin; all outputs are registered.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_05_raw,
    input  logic             coin_1_raw,
    input  logic             inhibit,
    output logic             coin_05,
    output logic             coin_1,
    output logic             coin_reject,
    output logic [CNT_W-1:0] count_05,
    output logic [CNT_W-1:0] count_1
);
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX = '1;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] r_lvl;
    logic [1:0] r_lvl_d;
    logic [7:0] r_cnt [2];
    logic       r_pend;
    logic [1:0] w_ev;
    logic       w_acc_05;
    logic       w_acc_1;
    assign w_ev = r_lvl & ~r_lvl_d;
    assign w_acc_1 = w_ev[1] & ~inhibit;
    // a 0.5 coin that collided with a 1 coin is deferred one cycle and then issued unconditionally
    assign w_acc_05 = (w_ev[0] & ~inhibit & ~w_ev[1]) | r_pend;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta      <= '0;
            r_sync      <= '0;
            r_lvl       <= '0;
            r_lvl_d     <= '0;
            r_cnt[0]    <= '0;
            r_cnt[1]    <= '0;
            r_pend      <= 1'b0;
            coin_05     <= 1'b0;
            coin_1      <= 1'b0;
            coin_reject <= 1'b0;
            count_05    <= '0;
            count_1     <= '0;
        end else begin
            r_meta  <= {coin_1_raw, coin_05_raw};
            r_sync  <= r_meta;
            r_lvl_d <= r_lvl;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_lvl[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LAST) begin
                    r_lvl[i] <= r_sync[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
            r_pend      <= w_ev[0] & w_ev[1] & ~inhibit;
            coin_1      <= w_acc_1;
            coin_05     <= w_acc_05;
            coin_reject <= (|w_ev) & inhibit;
            if (w_acc_1 && count_1 != MAX) count_1 <= count_1 + 1'b1;
            if (w_acc_05 && count_05 != MAX) count_05 <= count_05 + 1'b1;
        end
    end
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: directed checks of latency, debounce, inhibit, collision, saturation and reset
// A second instance with 2-bit counters shares all inputs and is used for the saturation case.
module tb_coin_input_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_05_raw = 1'b0;
    logic       coin_1_raw = 1'b0;
    logic       inhibit = 1'b0;
    logic       coin_05, coin_1, coin_reject;
    logic [7:0] count_05, count_1;
    logic       s_coin_05, s_coin_1, s_coin_reject;
    logic [1:0] s_count_05, s_count_1;
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n05 = 0, n1 = 0, nrej = 0, nov = 0, n05s = 0;
    int t05 = -1, t1 = -1, trej = -1;
    int b05, b1, brej, bov, b05s, en, nf;

    coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .coin_05_raw(coin_05_raw), .coin_1_raw(coin_1_raw),
        .inhibit(inhibit), .coin_05(coin_05), .coin_1(coin_1), .coin_reject(coin_reject),
        .count_05(count_05), .count_1(count_1)
    );

    coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .coin_05_raw(coin_05_raw), .coin_1_raw(coin_1_raw),
        .inhibit(inhibit), .coin_05(s_coin_05), .coin_1(s_coin_1), .coin_reject(s_coin_reject),
        .count_05(s_count_05), .count_1(s_count_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // cyc at the falling edge is the index of the rising edge that registered the outputs
    always @(negedge clk) begin
        if (coin_05) begin n05++; t05 = cyc; end
        if (coin_1) begin n1++; t1 = cyc; end
        if (coin_reject) begin nrej++; trej = cyc; end
        if (coin_05 && coin_1) nov++;
        if (s_coin_05) n05s++;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        coin_05_raw = 1'b0;
        coin_1_raw = 1'b0;
        inhibit = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic snap;
        b05 = n05; b1 = n1; brej = nrej; bov = nov; b05s = n05s;
    endtask

    initial begin
        step(2);
        check("rst_coin_05", int'(coin_05), 0);
        check("rst_coin_1", int'(coin_1), 0);
        check("rst_reject", int'(coin_reject), 0);
        check("rst_count_05", int'(count_05), 0);
        check("rst_count_1", int'(count_1), 0);
        reset = 1'b0;
        step(1);

        // clean 10-cycle press
        snap();
        coin_1_raw = 1'b1; en = cyc + 1;
        step(10);
        coin_1_raw = 1'b0;
        step(12);
        check("clean_pulses", n1 - b1, 1);
        check("clean_latency", t1, en + 6);
        check("clean_count_1", int'(count_1), 1);
        check("clean_no_05", n05 - b05, 0);
        check("clean_no_reject", nrej - brej, 0);

        // bounce then settle
        do_reset();
        snap();
        coin_05_raw = 1'b1; step(1);
        coin_05_raw = 1'b0; step(1);
        coin_05_raw = 1'b1; step(1);
        coin_05_raw = 1'b0; step(1);
        coin_05_raw = 1'b1; nf = cyc + 1;
        step(8);
        coin_05_raw = 1'b0;
        step(14);
        check("bounce_pulses", n05 - b05, 1);
        check("bounce_latency", t05, nf + 6);
        check("bounce_count_05", int'(count_05), 1);

        // 3-cycle glitch rejected, 4-cycle press accepted
        snap();
        coin_05_raw = 1'b1; step(3);
        coin_05_raw = 1'b0; step(12);
        check("glitch3_pulses", n05 - b05, 0);
        check("glitch3_count_05", int'(count_05), 1);
        snap();
        coin_05_raw = 1'b1; en = cyc + 1;
        step(4);
        coin_05_raw = 1'b0; step(12);
        check("min4_pulses", n05 - b05, 1);
        check("min4_latency", t05, en + 6);
        check("min4_count_05", int'(count_05), 2);

        // simultaneous insertion
        do_reset();
        snap();
        coin_05_raw = 1'b1; coin_1_raw = 1'b1; en = cyc + 1;
        step(8);
        coin_05_raw = 1'b0; coin_1_raw = 1'b0;
        step(14);
        check("sim_t1", t1, en + 6);
        check("sim_t05", t05, en + 7);
        check("sim_overlap", nov - bov, 0);
        check("sim_n1", n1 - b1, 1);
        check("sim_n05", n05 - b05, 1);
        check("sim_count_1", int'(count_1), 1);
        check("sim_count_05", int'(count_05), 1);

        // inhibited coin, then accepted coin
        do_reset();
        snap();
        inhibit = 1'b1;
        coin_1_raw = 1'b1; en = cyc + 1;
        step(8);
        coin_1_raw = 1'b0;
        step(14);
        check("inh_rejects", nrej - brej, 1);
        check("inh_latency", trej, en + 6);
        check("inh_no_coin_1", n1 - b1, 0);
        check("inh_count_1", int'(count_1), 0);
        inhibit = 1'b0;
        snap();
        coin_1_raw = 1'b1; en = cyc + 1;
        step(8);
        coin_1_raw = 1'b0;
        step(14);
        check("uninh_pulses", n1 - b1, 1);
        check("uninh_latency", t1, en + 6);
        check("uninh_no_reject", nrej - brej, 0);
        check("uninh_count_1", int'(count_1), 1);

        // saturation of the 2-bit instance
        do_reset();
        snap();
        for (int i = 1; i <= 6; i++) begin
            coin_05_raw = 1'b1; step(8);
            coin_05_raw = 1'b0; step(12);
            check($sformatf("sat_count_%0d", i), int'(s_count_05), (i < 3) ? i : 3);
        end
        check("sat_pulses", n05s - b05s, 6);
        check("wide_count_05", int'(count_05), 6);

        // reset while a press is qualifying
        do_reset();
        snap();
        coin_1_raw = 1'b1; en = cyc + 1;
        step(3);
        reset = 1'b1;
        step(1);
        check("midrst_no_pulse", n1 - b1, 0);
        check("midrst_count_1", int'(count_1), 0);
        reset = 1'b0;
        step(20);
        coin_1_raw = 1'b0;
        step(12);
        check("midrst_pulses", n1 - b1, 1);
        check("midrst_latency", t1, en + 4 + 6);
        check("midrst_count_after", int'(count_1), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
